// File: rtl/pov_frame_reader_if.sv
// Valid/ready pixel stream from the frame reader to the LED column driver.
interface pov_frame_reader_if #(
  parameter int DAT_WIDTH = 24
);
  logic [DAT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_last;
  logic                 out_ready;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/pov_frame_reader.sv
// Streams len RAM words from base_addr out on valid/ready; first beat 3 cycles after start; a credit-gated skid
// FIFO (with empty-bypass) soaks up the RAM latency so backpressure never drops a word. POV_REVERSE_EN adds descending reads.
module pov_frame_reader #(
  parameter int DAT_WIDTH  = 24,
  parameter int ADDR_WIDTH = 14,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef POV_REVERSE_EN
  input  logic                  reverse,
`endif
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic [DAT_WIDTH-1:0]  ram_q,
  output logic                  busy,
  output logic                  done,
  pov_frame_reader_if.master    out_if
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_step;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
`ifdef POV_REVERSE_EN
  logic                    rev_q, rev_d;
`endif
  logic [RD_LATENCY-1:0]   tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0]   tag_last_q, tag_last_d;
  logic [DAT_WIDTH:0]      mem_q [FIFO_DEPTH];
  logic [DAT_WIDTH:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]          fcnt_q, fcnt_d;

  logic [CNT_W-1:0]        inflight;
  logic                    credit_ok, issue, fifo_empty, tag_out;
  logic                    out_vld, beat, push, pop;
  logic [DAT_WIDTH:0]      head;

  // Credits count both stored words and reads still in the RAM pipe, so a push can never find the FIFO full.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(tag_vld_q[i]);
    end
  end

  assign credit_ok  = (CNT_W'(fcnt_q) + inflight) < CNT_W'(FIFO_DEPTH);
  assign issue      = (state_q == FETCH) && credit_ok;
  assign tag_out    = tag_vld_q[RD_LATENCY-1];
  assign fifo_empty = (fcnt_q == '0);

  // An empty FIFO passes the returning RAM word straight to the head; if it stalls it is stored unchanged.
  assign head    = fifo_empty ? {tag_last_q[RD_LATENCY-1], ram_q} : mem_q[rd_ptr_q];
  assign out_vld = !fifo_empty || tag_out;
  assign beat    = out_vld && out_if.out_ready;
  assign pop     = !fifo_empty && out_if.out_ready;
  assign push    = tag_out && !(fifo_empty && out_if.out_ready);

  assign out_if.out_valid = out_vld;
  assign out_if.out_data  = out_vld ? head[DAT_WIDTH-1:0] : '0;
  assign out_if.out_last  = out_vld && head[DAT_WIDTH];
  assign rdaddress        = addr_q;
  assign busy             = (state_q == FETCH) || (state_q == DRAIN);
  assign done             = (state_q == DONE);

  always_comb begin
    tag_vld_d     = '0;
    tag_last_d    = '0;
    tag_vld_d[0]  = issue;
    tag_last_d[0] = issue && (rem_q == (ADDR_WIDTH+1)'(1));
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_last_d[i] = tag_last_q[i-1];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {tag_last_q[RD_LATENCY-1], ram_q};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + (PTR_W+1)'(1);
      2'b01:   fcnt_d = fcnt_q - (PTR_W+1)'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_comb begin
`ifdef POV_REVERSE_EN
    addr_step = rev_q ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
`else
    addr_step = addr_q + ADDR_WIDTH'(1);
`endif
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
`ifdef POV_REVERSE_EN
    rev_d   = rev_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d = len;
`ifdef POV_REVERSE_EN
          rev_d  = reverse;
          addr_d = reverse ? (base_addr + len[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1)) : base_addr;
`else
          addr_d = base_addr;
`endif
          state_d = (len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (issue) begin
          addr_d = addr_step;
          rem_d  = rem_q - (ADDR_WIDTH+1)'(1);
          if (rem_q == (ADDR_WIDTH+1)'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      // The last-tagged word is the final one issued, so its acceptance implies pipe and FIFO are empty.
      DRAIN: begin
        if (beat && head[DAT_WIDTH]) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
`ifdef POV_REVERSE_EN
      rev_q      <= 1'b0;
`endif
      tag_vld_q  <= '0;
      tag_last_q <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
`ifdef POV_REVERSE_EN
      rev_q      <= rev_d;
`endif
      tag_vld_q  <= tag_vld_d;
      tag_last_q <= tag_last_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
    end
  end
endmodule

// File: tb/tb_pov_frame_reader.sv
// Directed bench for pov_frame_reader with a registered-address/registered-output RAM model.
module tb_pov_frame_reader;
  localparam int DW = 24;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
`ifdef POV_REVERSE_EN
  logic          reverse;
`endif
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] ram_q;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  pov_frame_reader_if #(.DAT_WIDTH(DW)) out_if ();

  pov_frame_reader #(
    .DAT_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .RD_LATENCY(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef POV_REVERSE_EN
    .reverse   (reverse),
`endif
    .base_addr (base_addr),
    .len       (len),
    .rdaddress (rdaddress),
    .ram_q     (ram_q),
    .busy      (busy),
    .done      (done),
    .out_if    (out_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [AW-1:0] ram_addr_r;
  initial for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i * 3);
  always @(posedge clk) begin
    ram_addr_r <= rdaddress;
    ram_q      <= ram[ram_addr_r];
  end

  logic [DW:0] beat_q [$];
  int          beat_cyc [$];
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_beat;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_if.out_valid || {out_if.out_last, out_if.out_data} != prev_beat)) stall_err++;
      if (out_if.out_valid && out_if.out_ready) begin
        beat_q.push_back({out_if.out_last, out_if.out_data});
        beat_cyc.push_back(cyc_n);
      end
      prev_stall = out_if.out_valid && !out_if.out_ready;
      prev_beat  = {out_if.out_last, out_if.out_data};
    end
  end

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
    return DW'(32'(a) * 3);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    beat_q.delete();
    beat_cyc.delete();
    stall_err = 0;
  endtask

  // Returns in the cycle after the start cycle; t is the start cycle number.
  task automatic start_frame(input logic [AW-1:0] b, input logic [AW:0] l, output int t);
    cyc();
    start = 1'b1; base_addr = b; len = l; t = cyc_n;
    cyc();
    start = 1'b0; base_addr = 14'h1234; len = 15'd7;
  endtask

  task automatic wait_done(input int budget, input bit toggle, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      out_if.out_ready = toggle ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      @(negedge clk);
      if (done) begin
        dcyc = cyc_n;
        break;
      end
      cyc();
    end
    out_if.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_if.out_ready = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    n_checks++; if (rdaddress !== '0) begin n_fail++; $display("FAIL reset_rdaddress: got %h want 0", rdaddress); end
    n_checks++; if (out_if.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_if.out_data); end
    n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_if.out_valid); end
    n_checks++; if (out_if.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_if.out_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int t, dcyc;
    out_if.out_ready = 1'b1;
    clear_log();
    start_frame(14'h0010, 15'd8, t);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (rdaddress !== AW'(16 + k)) begin n_fail++; $display("FAIL basic_rdaddr[%0d]: got %h want %h", k, rdaddress, AW'(16 + k)); end
      if (k == 0) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
      end
      cyc();
    end
    wait_done(20, 1'b0, dcyc);
    n_checks++; if (dcyc < 0) begin n_fail++; $display("FAIL basic_done_timeout: no done within budget"); end
    n_checks++; if (beat_q.size() != 8) begin n_fail++; $display("FAIL basic_count: got %0d want 8", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 8; i++) begin
      n_checks++;
      if (beat_q[i] !== {i == 7, exp_word(AW'(16 + i))}) begin
        n_fail++; $display("FAIL basic_beat[%0d]: got %h want %h", i, beat_q[i], {i == 7, exp_word(AW'(16 + i))});
      end
    end
    if (beat_cyc.size() == 8) begin
      n_checks++; if (beat_cyc[0] != t + 3) begin n_fail++; $display("FAIL basic_first_beat_cyc: got %0d want %0d", beat_cyc[0], t + 3); end
      n_checks++; if (beat_cyc[7] != t + 10) begin n_fail++; $display("FAIL basic_last_beat_cyc: got %0d want %0d", beat_cyc[7], t + 10); end
      n_checks++; if (dcyc != t + 11) begin n_fail++; $display("FAIL basic_done_cyc: got %0d want %0d", dcyc, t + 11); end
    end
    cyc();
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_stall();
    int t, dcyc;
    out_if.out_ready = 1'b1;
    clear_log();
    start_frame(14'h0010, 15'd8, t);
    wait_done(80, 1'b1, dcyc);
    n_checks++; if (dcyc < 0) begin n_fail++; $display("FAIL stall_done_timeout: no done within budget"); end
    n_checks++; if (beat_q.size() != 8) begin n_fail++; $display("FAIL stall_count: got %0d want 8", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 8; i++) begin
      n_checks++;
      if (beat_q[i] !== {i == 7, exp_word(AW'(16 + i))}) begin
        n_fail++; $display("FAIL stall_beat[%0d]: got %h want %h", i, beat_q[i], {i == 7, exp_word(AW'(16 + i))});
      end
    end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable stalls want 0", stall_err); end
    if (beat_cyc.size() == 8) begin
      n_checks++; if (dcyc != beat_cyc[7] + 1) begin n_fail++; $display("FAIL stall_done_cyc: got %0d want %0d", dcyc, beat_cyc[7] + 1); end
    end
    cyc();
  endtask

  task automatic test_wrap();
    int t, dcyc;
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 14'h3FFE; exp_a[1] = 14'h3FFF; exp_a[2] = 14'h0000; exp_a[3] = 14'h0001;
    out_if.out_ready = 1'b1;
    clear_log();
    start_frame(14'h3FFE, 15'd4, t);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (rdaddress !== exp_a[k]) begin n_fail++; $display("FAIL wrap_rdaddr[%0d]: got %h want %h", k, rdaddress, exp_a[k]); end
      cyc();
    end
    wait_done(20, 1'b0, dcyc);
    n_checks++; if (dcyc < 0) begin n_fail++; $display("FAIL wrap_done_timeout: no done within budget"); end
    n_checks++; if (beat_q.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 4; i++) begin
      n_checks++;
      if (beat_q[i] !== {i == 3, exp_word(exp_a[i])}) begin
        n_fail++; $display("FAIL wrap_beat[%0d]: got %h want %h", i, beat_q[i], {i == 3, exp_word(exp_a[i])});
      end
    end
    cyc();
  endtask

  task automatic test_len0();
    int t;
    out_if.out_ready = 1'b1;
    start_frame(14'h0010, 15'd0, t);
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL len0_done: got %b want 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b want 0", busy); end
    n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL len0_valid: got %b want 0", out_if.out_valid); end
    cyc();
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL len0_done_after: got %b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy_after: got %b want 0", busy); end
    n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL len0_valid_after: got %b want 0", out_if.out_valid); end
    cyc();
  endtask

  // A start two cycles into the frame and another in the done cycle must both be ignored.
  task automatic test_back_to_back();
    int t, dcyc, done_n;
    dcyc = -1; done_n = 0;
    out_if.out_ready = 1'b1;
    clear_log();
    start_frame(14'h0020, 15'd16, t);
    for (int i = 0; i < 40; i++) begin
      start = (cyc_n == t + 2) || (cyc_n == t + 19);
      base_addr = 14'h0200; len = 15'd5;
      @(negedge clk);
      if (done) begin
        done_n++;
        if (dcyc < 0) dcyc = cyc_n;
      end
      cyc();
    end
    start = 1'b0;
    n_checks++; if (dcyc != t + 19) begin n_fail++; $display("FAIL b2b_done_cyc: got %0d want %0d", dcyc, t + 19); end
    n_checks++; if (done_n != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", done_n); end
    n_checks++; if (beat_q.size() != 16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 16; i++) begin
      n_checks++;
      if (beat_q[i] !== {i == 15, exp_word(AW'(32 + i))}) begin
        n_fail++; $display("FAIL b2b_beat[%0d]: got %h want %h", i, beat_q[i], {i == 15, exp_word(AW'(32 + i))});
      end
    end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after: got %b want 0", busy); end
    cyc();
  endtask

  task automatic test_reset_mid();
    int t, dcyc;
    out_if.out_ready = 1'b1;
    clear_log();
    start_frame(14'h0050, 15'd10, t);
    while (cyc_n < t + 6) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (rdaddress !== '0) begin n_fail++; $display("FAIL rstmid_rdaddress: got %h want 0", rdaddress); end
    n_checks++; if (out_if.out_data !== '0) begin n_fail++; $display("FAIL rstmid_out_data: got %h want 0", out_if.out_data); end
    n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_if.out_valid); end
    n_checks++; if (out_if.out_last !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_last: got %b want 0", out_if.out_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done); end
    for (int j = 0; j < 4; j++) begin
      cyc();
      @(negedge clk);
      n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stray[%0d]: got valid %b want 0", j, out_if.out_valid); end
    end
    n_checks++; if (beat_q.size() != 3) begin n_fail++; $display("FAIL rstmid_count: got %0d want 3", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 3; i++) begin
      n_checks++;
      if (beat_q[i] !== {1'b0, exp_word(AW'(80 + i))}) begin
        n_fail++; $display("FAIL rstmid_beat[%0d]: got %h want %h", i, beat_q[i], {1'b0, exp_word(AW'(80 + i))});
      end
    end
    clear_log();
    start_frame(14'h0060, 15'd3, t);
    wait_done(20, 1'b0, dcyc);
    n_checks++; if (dcyc != t + 6) begin n_fail++; $display("FAIL rstmid_new_done_cyc: got %0d want %0d", dcyc, t + 6); end
    n_checks++; if (beat_q.size() != 3) begin n_fail++; $display("FAIL rstmid_new_count: got %0d want 3", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 3; i++) begin
      n_checks++;
      if (beat_q[i] !== {i == 2, exp_word(AW'(96 + i))}) begin
        n_fail++; $display("FAIL rstmid_new_beat[%0d]: got %h want %h", i, beat_q[i], {i == 2, exp_word(AW'(96 + i))});
      end
    end
    cyc();
  endtask

`ifdef POV_REVERSE_EN
  task automatic test_reverse();
    int t, dcyc;
    out_if.out_ready = 1'b1;
    clear_log();
    reverse = 1'b1;
    cyc();
    start_frame(14'h0100, 15'd3, t);
    reverse = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (rdaddress !== AW'(14'h0102 - k)) begin n_fail++; $display("FAIL rev_rdaddr[%0d]: got %h want %h", k, rdaddress, AW'(14'h0102 - k)); end
      cyc();
    end
    wait_done(20, 1'b0, dcyc);
    n_checks++; if (beat_q.size() != 3) begin n_fail++; $display("FAIL rev_count: got %0d want 3", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 3; i++) begin
      n_checks++;
      if (beat_q[i] !== {i == 2, exp_word(AW'(14'h0102 - i))}) begin
        n_fail++; $display("FAIL rev_beat[%0d]: got %h want %h", i, beat_q[i], {i == 2, exp_word(AW'(14'h0102 - i))});
      end
    end
    cyc();
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_if.out_ready = 1'b0;
`ifdef POV_REVERSE_EN
    reverse = 1'b0;
`endif
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_len0();
    test_back_to_back();
    test_reset_mid();
`ifdef POV_REVERSE_EN
    test_reverse();
`endif
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
